sseg_scan_ctrl: RTL and testbench

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - eight-digit multiplexed seven-segment scanner with a
// 16-entry scrolling message buffer.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int SCROLL_DIV  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       scroll_en,
  input  logic       msg_wr,
  input  logic [3:0] msg_addr,
  input  logic [2:0] msg_data,
  output logic [2:0] code,
  output logic [7:0] an,
  output logic [2:0] digit_sel,
  output logic       frame_tick
);

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCR_W = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_DIV - 1);
  localparam logic [2:0] CODE_BLANK = 3'd6;
  // Entry 0 sits in the low bits: "n180116 " followed by eight blanks.
  localparam logic [47:0] MSG_INIT = {
    3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6,
    3'd6, 3'd5, 3'd2, 3'd2, 3'd4, 3'd3, 3'd2, 3'd1
  };

  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [SCR_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic             scroll_pend_q, scroll_pend_d;
  logic [3:0]       offset_q, offset_d;
  logic [2:0]       digit_sel_q, digit_sel_d;
  logic [7:0]       an_q, an_d;
  logic [2:0]       code_q, code_d;
  logic             frame_tick_q, frame_tick_d;
  logic             en_q, en_d;
  logic [2:0]       msg_buf_q [16];
  logic [2:0]       msg_buf_d [16];

  logic       refresh_tick;
  logic       frame_wrap;
  logic       scroll_term;
  logic [3:0] rd_idx;

  always_comb begin
    ref_cnt_d     = ref_cnt_q;
    scroll_cnt_d  = scroll_cnt_q;
    scroll_pend_d = scroll_pend_q;
    offset_d      = offset_q;
    digit_sel_d   = digit_sel_q;
    an_d          = an_q;
    code_d        = code_q;
    frame_tick_d  = 1'b0;
    en_d          = en;
    msg_buf_d     = msg_buf_q;

    refresh_tick = en && (ref_cnt_q == REF_LAST);
    frame_wrap   = refresh_tick && (digit_sel_q == 3'd7);
    scroll_term  = en && scroll_en && (scroll_cnt_q == SCR_LAST);

    if (en) begin
      ref_cnt_d = refresh_tick ? '0 : ref_cnt_q + 1'b1;
    end
    if (refresh_tick) begin
      digit_sel_d = digit_sel_q + 3'd1;
    end
    frame_tick_d = frame_wrap;

    // Offset only moves at a frame boundary so a frame never mixes offsets.
    if (frame_wrap && scroll_pend_q) begin
      offset_d      = offset_q + 4'd1;
      scroll_pend_d = 1'b0;
    end
    if (!scroll_en) begin
      scroll_cnt_d  = '0;
      scroll_pend_d = 1'b0;
    end else if (en) begin
      scroll_cnt_d = scroll_term ? '0 : scroll_cnt_q + 1'b1;
      if (scroll_term) begin
        scroll_pend_d = 1'b1;
      end
    end

    rd_idx = offset_d + 4'd7 - {1'b0, digit_sel_d};
    if (!en) begin
      an_d   = 8'hFF;
      code_d = CODE_BLANK;
    end else if (refresh_tick || !en_q) begin
      an_d   = ~(8'd1 << digit_sel_d);
      code_d = msg_buf_q[rd_idx];
    end

    if (msg_wr) begin
      msg_buf_d[msg_addr] = msg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q     <= '0;
      scroll_cnt_q  <= '0;
      scroll_pend_q <= 1'b0;
      offset_q      <= '0;
      digit_sel_q   <= '0;
      an_q          <= 8'hFF;
      code_q        <= CODE_BLANK;
      frame_tick_q  <= 1'b0;
      en_q          <= 1'b1;
      for (int i = 0; i < 16; i++) begin
        msg_buf_q[i] <= MSG_INIT[i*3 +: 3];
      end
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      scroll_cnt_q  <= scroll_cnt_d;
      scroll_pend_q <= scroll_pend_d;
      offset_q      <= offset_d;
      digit_sel_q   <= digit_sel_d;
      an_q          <= an_d;
      code_q        <= code_d;
      frame_tick_q  <= frame_tick_d;
      en_q          <= en_d;
      for (int i = 0; i < 16; i++) begin
        msg_buf_q[i] <= msg_buf_d[i];
      end
    end
  end

  assign code       = code_q;
  assign an         = an_q;
  assign digit_sel  = digit_sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed table-driven bench for sseg_scan_ctrl
// with REFRESH_DIV=4 and SCROLL_DIV=40.
module tb_sseg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       scroll_en = 1'b0;
  logic       msg_wr = 1'b0;
  logic [3:0] msg_addr = 4'd0;
  logic [2:0] msg_data = 3'd0;
  logic [2:0] code;
  logic [7:0] an;
  logic [2:0] digit_sel;
  logic       frame_tick;

  sseg_scan_ctrl #(.REFRESH_DIV(4), .SCROLL_DIV(40)) dut (
    .clk(clk), .rst(rst), .en(en), .scroll_en(scroll_en),
    .msg_wr(msg_wr), .msg_addr(msg_addr), .msg_data(msg_data),
    .code(code), .an(an), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [2:0] code;
    logic [2:0] sel;
    logic       ft;
  } vec_t;

  vec_t vq[$];
  int   edge_n = 0;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) tick();
  endtask

  task automatic do_reset(input logic en_v, input logic scroll_v);
    rst = 1'b1;
    msg_wr = 1'b0;
    repeat (2) @(negedge clk);
    en = en_v;
    scroll_en = scroll_v;
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic add(input int c, input logic [7:0] a, input logic [2:0] cd,
                     input logic [2:0] s, input logic f);
    vec_t v;
    v.cyc = c; v.an = a; v.code = cd; v.sel = s; v.ft = f;
    vq.push_back(v);
  endtask

  task automatic apply_vecs(input string tag);
    foreach (vq[i]) begin
      run_to(vq[i].cyc);
      chk($sformatf("%s e%0d an", tag, vq[i].cyc), {24'd0, an}, {24'd0, vq[i].an});
      chk($sformatf("%s e%0d code", tag, vq[i].cyc), {29'd0, code}, {29'd0, vq[i].code});
      chk($sformatf("%s e%0d sel", tag, vq[i].cyc), {29'd0, digit_sel}, {29'd0, vq[i].sel});
      chk($sformatf("%s e%0d ft", tag, vq[i].cyc), {31'd0, frame_tick}, {31'd0, vq[i].ft});
    end
    vq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Plain scan, no scrolling: buffer n180116 shown right to left.
    do_reset(1'b1, 1'b0);
    add(0,  8'hFF, 3'd6, 3'd0, 1'b0);
    add(3,  8'hFF, 3'd6, 3'd0, 1'b0);
    add(4,  8'hFD, 3'd5, 3'd1, 1'b0);
    add(5,  8'hFD, 3'd5, 3'd1, 1'b0);
    add(8,  8'hFB, 3'd2, 3'd2, 1'b0);
    add(12, 8'hF7, 3'd2, 3'd3, 1'b0);
    add(16, 8'hEF, 3'd4, 3'd4, 1'b0);
    add(20, 8'hDF, 3'd3, 3'd5, 1'b0);
    add(24, 8'hBF, 3'd2, 3'd6, 1'b0);
    add(28, 8'h7F, 3'd1, 3'd7, 1'b0);
    add(31, 8'h7F, 3'd1, 3'd7, 1'b0);
    add(32, 8'hFE, 3'd6, 3'd0, 1'b1);
    add(33, 8'hFE, 3'd6, 3'd0, 1'b0);
    add(36, 8'hFD, 3'd5, 3'd1, 1'b0);
    add(63, 8'h7F, 3'd1, 3'd7, 1'b0);
    add(64, 8'hFE, 3'd6, 3'd0, 1'b1);
    add(65, 8'hFE, 3'd6, 3'd0, 1'b0);
    apply_vecs("scan");

    // Scrolling from reset: pending at 40, offset steps at the 64 wrap.
    do_reset(1'b1, 1'b1);
    run_to(39);
    chk("pend e39", {31'd0, dut.scroll_pend_q}, 32'd0);
    tick();
    chk("pend e40", {31'd0, dut.scroll_pend_q}, 32'd1);
    add(60, 8'h7F, 3'd1, 3'd7, 1'b0);
    add(64, 8'hFE, 3'd6, 3'd0, 1'b1);
    add(68, 8'hFD, 3'd6, 3'd1, 1'b0);
    add(92, 8'h7F, 3'd2, 3'd7, 1'b0);
    apply_vecs("scroll");
    chk("offset e92", {28'd0, dut.offset_q}, 32'd1);
    chk("pend e92", {31'd0, dut.scroll_pend_q}, 32'd1);

    // Drop en one cycle into digit 3, then resume with 3 slot cycles left.
    do_reset(1'b1, 1'b0);
    run_to(13);
    en = 1'b0;
    tick();
    chk("en0 an", {24'd0, an}, 32'hFF);
    chk("en0 code", {29'd0, code}, 32'd6);
    chk("en0 sel", {29'd0, digit_sel}, 32'd3);
    repeat (5) tick();
    chk("en0 hold sel", {29'd0, digit_sel}, 32'd3);
    chk("en0 hold an", {24'd0, an}, 32'hFF);
    en = 1'b1;
    tick();
    chk("en1 an", {24'd0, an}, 32'hF7);
    chk("en1 code", {29'd0, code}, 32'd2);
    tick();
    chk("en1+1 sel", {29'd0, digit_sel}, 32'd3);
    tick();
    chk("en1+2 sel", {29'd0, digit_sel}, 32'd4);
    chk("en1+2 an", {24'd0, an}, 32'hEF);
    chk("en1+2 code", {29'd0, code}, 32'd4);

    // Buffer writes against the displayed digit and same-edge read/write.
    do_reset(1'b1, 1'b0);
    run_to(28);
    msg_wr = 1'b1; msg_addr = 4'd0; msg_data = 3'd4;
    tick();
    msg_wr = 1'b0;
    chk("wr shown e29", {29'd0, code}, 32'd1);
    run_to(31);
    chk("wr shown e31", {29'd0, code}, 32'd1);
    msg_wr = 1'b1; msg_addr = 4'd7; msg_data = 3'd2;
    tick();
    msg_wr = 1'b0;
    chk("wr same edge e32", {29'd0, code}, 32'd6);
    msg_wr = 1'b1; msg_addr = 4'd6; msg_data = 3'd7;
    tick();
    msg_wr = 1'b0;
    run_to(36);
    chk("code7 stored e36", {29'd0, code}, 32'd7);
    run_to(60);
    chk("wr seen e60", {29'd0, code}, 32'd4);
    run_to(64);
    chk("wr seen e64", {29'd0, code}, 32'd2);
    run_to(66);

    // Asynchronous reset between edges restores everything at once.
    #2 rst = 1'b1;
    #1;
    chk("arst an", {24'd0, an}, 32'hFF);
    chk("arst code", {29'd0, code}, 32'd6);
    chk("arst sel", {29'd0, digit_sel}, 32'd0);
    chk("arst ft", {31'd0, frame_tick}, 32'd0);
    chk("arst buf0", {29'd0, dut.msg_buf_q[0]}, 32'd1);
    chk("arst buf6", {29'd0, dut.msg_buf_q[6]}, 32'd5);
    chk("arst buf7", {29'd0, dut.msg_buf_q[7]}, 32'd6);
    do_reset(1'b1, 1'b0);
    run_to(28);
    chk("post arst e28", {29'd0, code}, 32'd1);
    run_to(36);
    chk("post arst e36", {29'd0, code}, 32'd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
